unified_mem_ctrl: RTL and testbench

//  Parametrised unified instruction/data memory for the multicycle RV32I core.

---
 rtl/unified_mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_unified_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory for a multicycle RV32I core: sized little-endian
// accesses, req/ready handshake with configurable latency, IR/MDR latching, misalign flag.
module unified_mem_ctrl #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_req,
  input  logic            IorD_reg,
  input  logic            MemWrite_reg,
  input  logic            IRWrite_reg,
  input  logic [2:0]      funct3_reg,
  input  logic [XLEN-1:0] pc_reg,
  input  logic [XLEN-1:0] AluOut_reg,
  input  logic [XLEN-1:0] rsB_reg,
  output logic [XLEN-1:0] addr_reg,
  output logic [XLEN-1:0] instruction_reg,
  output logic [XLEN-1:0] data_reg,
  output logic            mem_ready,
  output logic            misalign_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        accept, finish;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_word_reg;
  logic [AW-1:0]   rd_idx;

  logic [2:0]      funct3_lat_reg;
  logic            iord_lat_reg, memwrite_lat_reg, irwrite_lat_reg, misalign_lat_reg;

  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_size, ld_size;
  logic            req_mis, wr_en;
  logic [3:0]      lane_en;
  logic [7:0]      lane_data [4];
  logic [XLEN-1:0] ld_shifted, ld_value;

  // Fetches are always word-sized; data accesses are sized by funct3[1:0], reserved codes as word.
  function automatic logic [1:0] size_of(input logic iord, input logic [2:0] f3);
    if (!iord)              return SZ_WORD;
    else if (f3[1:0] == 2'b00) return SZ_BYTE;
    else if (f3[1:0] == 2'b01) return SZ_HALF;
    else                    return SZ_WORD;
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (mem_req) begin
          state_next = BUSY;
          cnt_next   = 2'd0;
        end
      end
      BUSY: begin
        if (cnt_reg == LAST_CNT) state_next = DONE;
        else                     cnt_next   = cnt_reg + 2'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    accept    = (state_reg == IDLE) && mem_req && !reset;
    finish    = (state_reg == BUSY) && (cnt_reg == LAST_CNT);
    mem_ready = (state_reg == DONE);
  end

  // ---------------- request decode ----------------
  always_comb begin
    req_addr = IorD_reg ? AluOut_reg : pc_reg;
    req_size = size_of(IorD_reg, funct3_reg);
    case (req_size)
      SZ_BYTE: req_mis = 1'b0;
      SZ_HALF: req_mis = req_addr[0];
      default: req_mis = |req_addr[1:0];
    endcase
    wr_en  = accept && IorD_reg && MemWrite_reg && !req_mis;
    rd_idx = (state_reg == IDLE) ? req_addr[AW+1:2] : addr_reg[AW+1:2];
  end

  // Store data is replicated so each lane picks its byte regardless of the offset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] = (req_size == SZ_BYTE) ? (req_addr[1:0] == 2'(gi)) :
                           (req_size == SZ_HALF) ? (req_addr[1] == 1'(gi / 2)) : 1'b1;
      assign lane_data[gi] = (req_size == SZ_BYTE) ? rsB_reg[7:0] :
                             (req_size == SZ_HALF) ? rsB_reg[(gi % 2) * 8 +: 8] :
                                                     rsB_reg[gi * 8 +: 8];
    end
  endgenerate

  // ---------------- memory array (registered read) ----------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[req_addr[AW+1:2]][b*8 +: 8] <= lane_data[b];
      end
    end
    rd_word_reg <= mem[rd_idx];
  end

  // ---------------- load extraction ----------------
  always_comb begin
    ld_size    = size_of(iord_lat_reg, funct3_lat_reg);
    ld_shifted = rd_word_reg >> {addr_reg[1:0], 3'b000};
    case (ld_size)
      SZ_BYTE: ld_value = funct3_lat_reg[2] ? {24'd0, ld_shifted[7:0]}
                                            : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_value = funct3_lat_reg[2] ? {16'd0, ld_shifted[15:0]}
                                            : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_value = rd_word_reg;
    endcase
  end

  // ---------------- request latch, IR / MDR, fault ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg         <= '0;
      instruction_reg  <= '0;
      data_reg         <= '0;
      misalign_fault   <= 1'b0;
      funct3_lat_reg   <= 3'd0;
      iord_lat_reg     <= 1'b0;
      memwrite_lat_reg <= 1'b0;
      irwrite_lat_reg  <= 1'b0;
      misalign_lat_reg <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg         <= req_addr;
        funct3_lat_reg   <= funct3_reg;
        iord_lat_reg     <= IorD_reg;
        memwrite_lat_reg <= MemWrite_reg;
        irwrite_lat_reg  <= IRWrite_reg;
        misalign_lat_reg <= req_mis;
        if (req_mis) misalign_fault <= 1'b1;
      end
      // A misaligned access still completes on schedule but leaves IR/MDR untouched.
      if (finish && !misalign_lat_reg) begin
        if (!iord_lat_reg) begin
          data_reg <= rd_word_reg;
          if (irwrite_lat_reg) instruction_reg <= rd_word_reg;
        end else if (!memwrite_lat_reg) begin
          data_reg <= ld_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: three instances (read latency 1,2,3) share stimulus and
// are compared against a byte-level memory model kept in the bench.
module tb_unified_mem_ctrl;

  localparam int NDUT  = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, iord, memwrite, irwrite;
  logic [2:0]  funct3;
  logic [31:0] pc, aluout, rsb;

  logic [31:0] addr_o [NDUT];
  logic [31:0] ir_o   [NDUT];
  logic [31:0] data_o [NDUT];
  logic        ready  [NDUT];
  logic        fault  [NDUT];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      unified_mem_ctrl #(.XLEN(32), .DEPTH(DEPTH), .READ_LATENCY(gi + 1)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .mem_req         (mem_req),
        .IorD_reg        (iord),
        .MemWrite_reg    (memwrite),
        .IRWrite_reg     (irwrite),
        .funct3_reg      (funct3),
        .pc_reg          (pc),
        .AluOut_reg      (aluout),
        .rsB_reg         (rsb),
        .addr_reg        (addr_o[gi]),
        .instruction_reg (ir_o[gi]),
        .data_reg        (data_o[gi]),
        .mem_ready       (ready[gi]),
        .misalign_fault  (fault[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  // Reference model: memory as words addressed modulo DEPTH, plus expected registers.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_ir, exp_data, exp_addr;
  logic        exp_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int access_bytes(input bit d, input bit [2:0] f3);
    if (!d) return 4;
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic void model_apply(input bit d, input bit mw, input bit irw, input bit [2:0] f3,
                                      input logic [31:0] pcv, input logic [31:0] aluv,
                                      input logic [31:0] rsbv);
    logic [31:0] a, v, ba;
    int n;
    a = d ? aluv : pcv;
    n = access_bytes(d, f3);
    exp_addr = a;
    if ((a % n) != 0) begin
      exp_fault = 1'b1;
    end else if (!d) begin
      v = model_mem[(a / 4) % DEPTH];
      exp_data = v;
      if (irw) exp_ir = v;
    end else if (mw) begin
      for (int k = 0; k < n; k++) begin
        ba = a + k;
        model_mem[(ba / 4) % DEPTH][(ba % 4) * 8 +: 8] = rsbv[k*8 +: 8];
      end
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) begin
        ba = a + k;
        v[k*8 +: 8] = model_mem[(ba / 4) % DEPTH][(ba % 4) * 8 +: 8];
      end
      if (n < 4 && !f3[2] && v[n*8-1]) begin
        for (int b = n * 8; b < 32; b++) v[b] = 1'b1;
      end
      exp_data = v;
    end
  endfunction

  // One request; every instance must pulse ready once, latency+1 cycles after accept.
  task automatic access(input bit d, input bit mw, input bit irw, input bit [2:0] f3,
                        input logic [31:0] pcv, input logic [31:0] aluv, input logic [31:0] rsbv);
    int          first [NDUT];
    int          cnt   [NDUT];
    logic [31:0] d_at  [NDUT];
    logic [31:0] i_at  [NDUT];
    logic [31:0] a_at  [NDUT];
    logic        f_at  [NDUT];
    model_apply(d, mw, irw, f3, pcv, aluv, rsbv);
    @(negedge clk);
    iord = d; memwrite = mw; irwrite = irw; funct3 = f3;
    pc = pcv; aluout = aluv; rsb = rsbv; mem_req = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      first[i] = -1; cnt[i] = 0; d_at[i] = '0; i_at[i] = '0; a_at[i] = '0; f_at[i] = 1'b0;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) mem_req = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
        if (ready[i]) begin
          cnt[i]++;
          if (first[i] < 0) begin
            first[i] = c; d_at[i] = data_o[i]; i_at[i] = ir_o[i];
            a_at[i] = addr_o[i]; f_at[i] = fault[i];
          end
        end
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("latency[%0d]", i), 32'(first[i]), 32'(i + 2));
      check($sformatf("ready_pulses[%0d]", i), 32'(cnt[i]), 32'd1);
      check($sformatf("data_reg[%0d]", i), d_at[i], exp_data);
      check($sformatf("instruction_reg[%0d]", i), i_at[i], exp_ir);
      check($sformatf("addr_reg[%0d]", i), a_at[i], exp_addr);
      check($sformatf("misalign_fault[%0d]", i), 32'(f_at[i]), 32'(exp_fault));
    end
    txn_no++;
    $display("txn %0d: iord=%0d we=%0d f3=%0d addr=%08h rsB=%08h -> data=%08h ir=%08h fault=%0d",
             txn_no, d, mw, f3, d ? aluv : pcv, rsbv, d_at[0], i_at[0], f_at[0]);
  endtask

  // Hold mem_req for h cycles: one access per IDLE visit, none queued.
  task automatic hold_test(input int h);
    int cnt [NDUT];
    int expc;
    model_apply(1'b1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd4, 32'd0);
    @(negedge clk);
    iord = 1'b1; memwrite = 1'b0; irwrite = 1'b0; funct3 = 3'b010; aluout = 32'd4;
    mem_req = 1'b1;
    for (int i = 0; i < NDUT; i++) cnt[i] = 0;
    for (int t = 0; t < h + 8; t++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) if (ready[i]) cnt[i]++;
      if (t == h - 1) mem_req = 1'b0;
    end
    for (int i = 0; i < NDUT; i++) begin
      // Request seen each time the FSM is back in IDLE: every latency+2 cycles.
      expc = 0;
      for (int t = 0; t < h; t += i + 3) expc++;
      check($sformatf("hold_accesses[%0d]", i), 32'(cnt[i]), 32'(expc));
      check($sformatf("hold_data[%0d]", i), data_o[i], exp_data);
    end
    txn_no++;
    $display("txn %0d: mem_req held %0d cycles, accesses=%0d/%0d/%0d",
             txn_no, h, cnt[0], cnt[1], cnt[2]);
  endtask

  // Reset lands while every instance is still in BUSY of a load.
  task automatic reset_in_busy();
    int cnt [NDUT];
    @(negedge clk);
    iord = 1'b1; memwrite = 1'b0; irwrite = 1'b0; funct3 = 3'b010; aluout = 32'd8;
    mem_req = 1'b1;
    @(negedge clk);
    mem_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NDUT; i++) cnt[i] = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) if (ready[i]) cnt[i]++;
    end
    exp_ir = '0; exp_data = '0; exp_addr = '0; exp_fault = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("abort_ready[%0d]", i), 32'(cnt[i]), 32'd0);
      check($sformatf("abort_data[%0d]", i), data_o[i], 32'd0);
      check($sformatf("abort_ir[%0d]", i), ir_o[i], 32'd0);
      check($sformatf("abort_addr[%0d]", i), addr_o[i], 32'd0);
      check($sformatf("abort_fault[%0d]", i), 32'(fault[i]), 32'd0);
    end
    txn_no++;
    $display("txn %0d: reset during BUSY of lw @8", txn_no);
  endtask

  initial begin
    logic [31:0] a;
    bit          d, mw, irw;
    bit   [2:0]  f3;

    reset = 1'b1; mem_req = 1'b0; iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
    funct3 = 3'd0; pc = '0; aluout = '0; rsb = '0;
    exp_ir = '0; exp_data = '0; exp_addr = '0; exp_fault = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_ready[%0d]", i), 32'(ready[i]), 32'd0);
      check($sformatf("rst_data[%0d]", i), data_o[i], 32'd0);
      check($sformatf("rst_ir[%0d]", i), ir_o[i], 32'd0);
      check($sformatf("rst_fault[%0d]", i), 32'(fault[i]), 32'd0);
    end

    // Fill the whole array so every later load reads defined contents.
    for (int w = 0; w < DEPTH; w++) access(1, 1, 0, 3'b010, 0, 32'(w * 4), $urandom);

    // Stores of words, then sw over word0.
    access(1, 1, 0, 3'b010, 0, 0, 32'h11223344);
    access(1, 1, 0, 3'b010, 0, 4, 32'h55667788);
    access(1, 1, 0, 3'b010, 0, 8, 32'h45628748);
    access(1, 1, 0, 3'b010, 0, 0, 32'haabbccdd);
    access(1, 0, 0, 3'b010, 0, 0, 0);
    check("sw_word0", data_o[0], 32'haabbccdd);

    // sb, then signed/unsigned byte and half loads.
    access(1, 1, 0, 3'b010, 0, 0, 32'h11223344);
    access(1, 1, 0, 3'b000, 0, 1, 32'h000000dd);
    access(1, 0, 0, 3'b010, 0, 0, 0);
    check("sb_word0", data_o[0], 32'h1122dd44);
    access(1, 0, 0, 3'b000, 0, 1, 0);
    check("lb_signext", data_o[0], 32'hffffffdd);
    access(1, 0, 0, 3'b100, 0, 1, 0);
    check("lbu_zeroext", data_o[1], 32'h000000dd);
    access(1, 0, 0, 3'b001, 0, 2, 0);
    check("lh_upper", data_o[2], 32'h00001122);

    // Fetch with and without IRWrite; MemWrite on a fetch must not store.
    access(0, 0, 1, 3'b000, 8, 0, 0);
    check("fetch_ir", ir_o[2], 32'h45628748);
    access(0, 1, 0, 3'b000, 0, 0, 32'hdeadbeef);
    check("fetch_ir_held", ir_o[0], 32'h45628748);
    check("fetch_mdr", data_o[0], 32'h1122dd44);

    // Misaligned lw/sh leave memory and MDR alone; fault is sticky.
    access(1, 0, 0, 3'b010, 0, 2, 0);
    access(1, 1, 0, 3'b001, 0, 3, 32'hcafe1234);
    check("mis_fault", 32'(fault[1]), 32'd1);
    access(1, 0, 0, 3'b010, 0, 0, 0);
    check("mis_nowrite", data_o[1], 32'h1122dd44);
    access(1, 0, 0, 3'b010, 0, 4, 0);
    check("post_mis_lw", data_o[0], 32'h55667788);
    access(0, 0, 1, 3'b000, 6, 0, 0);

    hold_test(10);

    // Upper address bits wrap: 0x404 aliases word1.
    access(1, 1, 0, 3'b010, 0, 32'h404, 32'h0badf00d);
    access(1, 0, 0, 3'b010, 0, 4, 0);
    check("alias_word1", data_o[2], 32'h0badf00d);

    // Random mix of fetches, loads and stores over the full address space.
    for (int n = 0; n < 200; n++) begin
      d   = 1'($urandom_range(0, 3) != 0);
      mw  = 1'($urandom_range(0, 1));
      irw = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (d) access(d, mw, irw, f3, $urandom, a, $urandom);
      else   access(d, mw, irw, f3, a, $urandom, $urandom);
    end

    reset_in_busy();
    access(0, 0, 1, 3'b000, 4, 0, 0);
    access(1, 0, 0, 3'b010, 0, 8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so a stuck run still reports.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
